// File: rtl/uart_tx_fifo.sv
// Buffered 8N1/8N2 UART transmitter.
// Bytes enter a circular FIFO and are serialised LSB first on RsTx.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 3_000_000,
    parameter int FIFO_DEPTH = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    data_in,
    input  logic                          valid_in,
    output logic                          ready_in,
    output logic                          RsTx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CLK_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [1:0]    STOP_LAST = 2'(STOP_BITS - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);

    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("uart_tx_fifo: CLKS_PER_BIT must be at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    state_t        r_state;
    logic [CW-1:0] r_clk_cnt;
    logic [2:0]    r_bit;
    logic [1:0]    r_stop;
    logic [7:0]    r_shift;
    logic          r_tx;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_bit_end;
    logic w_pop;

    assign w_full    = (r_count == FULL_CNT);
    assign w_empty   = (r_count == '0);
    assign ready_in  = !w_full && !rst;
    assign w_push    = valid_in && ready_in;
    assign w_bit_end = (r_clk_cnt == CLK_LAST);
    // Pops only from registered state, so a fresh byte waits one edge.
    assign w_pop = !w_empty &&
                   ((r_state == IDLE) ||
                    (r_state == STOP && w_bit_end && r_stop == STOP_LAST));

    assign RsTx       = r_tx;
    assign busy       = (r_state != IDLE) || !w_empty;
    assign fifo_count = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_clk_cnt <= '0;
            r_bit     <= '0;
            r_stop    <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_shift   <= r_mem[r_rptr];
                        r_clk_cnt <= '0;
                        r_bit     <= '0;
                        r_stop    <= '0;
                        r_state   <= START;
                        r_tx      <= 1'b0;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        r_state   <= DATA;
                        r_tx      <= r_shift[0];
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        if (r_bit == 3'd7) begin
                            r_stop  <= '0;
                            r_state <= STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit   <= r_bit + 1'b1;
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_tx    <= r_shift[1];
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        if (r_stop == STOP_LAST) begin
                            // Chain straight into the next start bit when queued.
                            if (w_pop) begin
                                r_shift <= r_mem[r_rptr];
                                r_bit   <= '0;
                                r_stop  <= '0;
                                r_state <= START;
                                r_tx    <= 1'b0;
                            end else begin
                                r_state <= IDLE;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            r_stop <= r_stop + 1'b1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered UART transmitter that drains the sobel pipeline's output stream onto the board's serial TX pin. It accepts bytes on a valid/ready interface, queues them in an internal FIFO, and serialises each one as 8N1 (or 8N2) at a fixed baud rate derived from the system clock. It sits downstream of `sobel_applier`: the applier's `data_out`/`valid_out` connect to `data_in`/`valid_in`, and `ready_in` drives the applier's `ready_out`. It is the transmit counterpart of `uart_rx` and can be looped back into it.

## Interface
- `CLK_FREQ`, 100_000_000: system clock frequency in Hz.
- `BAUD_RATE`, 3_000_000: line rate in bits per second.
- `FIFO_DEPTH`, 16: number of FIFO entries. Must be a power of two, ≥2.
- `STOP_BITS`, 1: number of stop bits, 1 or 2.
- Derived `CLKS_PER_BIT = CLK_FREQ / BAUD_RATE`, integer-truncated. The default is 33. Elaboration fails if the value is below 2.

Ports:
- `clk`  in  1: the single clock. All logic is on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `data_in`  in  8: byte to transmit.
- `valid_in`  in  1: `data_in` is valid.
- `ready_in`  out  1: block can accept a byte this cycle.
- `RsTx`  out  1: serial line, idle high.
- `busy`  out  1: a frame is on the line or the FIFO is non-empty.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation
- **Push.** A byte is accepted on an edge where `valid_in && ready_in`.
  - `ready_in = !full && !rst`, combinational from the registered count.
  - `data_in` is ignored when `ready_in` is 0. The upstream holds the byte, so nothing is lost or duplicated.
- **FIFO.** Circular buffer with read and write pointers that wrap modulo `FIFO_DEPTH`.
  - A push and a pop on the same edge leave `fifo_count` unchanged.
  - There is no fall-through. A pop uses the registered non-empty flag, so a byte written on edge N is popped on edge N+1 at the earliest.
- **FSM states.** IDLE, START, DATA, STOP.
  - IDLE: `RsTx`=1. If the FIFO is non-empty, pop the head into the shift register, clear the bit counter and clock counter, and go to START.
  - START: `RsTx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: `RsTx`=shift[0], LSB first. Each bit lasts `CLKS_PER_BIT` cycles and the shift register moves right between bits. After bit 7, go to STOP.
  - STOP: `RsTx`=1 for `STOP_BITS*CLKS_PER_BIT` cycles. On the final cycle:
    - if the FIFO is non-empty, pop and go directly to START, so there is no idle gap between frames;
    - otherwise go to IDLE.
- **Counters.** The clock counter counts 0..`CLKS_PER_BIT`-1. The bit index is 3 bits. The stop counter counts to `STOP_BITS`.
- **Output register.** `RsTx` is registered and driven from the next-state value, so it is glitch-free.
- **Busy.** `busy` = (state != IDLE) || (`fifo_count` != 0).

## Timing
- **Reset values** while `rst` is high and on the first cycle after:
  - `RsTx`=1, state IDLE, `fifo_count`=0, `busy`=0;
  - `ready_in`=0 while `rst` is high and 1 on the first cycle after release;
  - pointers = 0.
- **Reset mid-frame.** On the edge where `rst` is sampled high:
  - the frame is abandoned and `RsTx` is 1 from the next cycle;
  - the FIFO is flushed;
  - no partial byte is resumed.
- **Latency.** If a byte is accepted on edge N into an empty FIFO with the FSM in IDLE:
  - it is popped on edge N+1;
  - `RsTx` is low from edge N+1 onward. This is the first start-bit cycle.
- **Bit and frame length.** Each bit is exactly `CLKS_PER_BIT` cycles. A frame is `(9+STOP_BITS)*CLKS_PER_BIT` cycles: 330 at the defaults.
- **Streaming rate.** Back-to-back frames are contiguous. Sustained throughput is one byte per frame time.
- **FIFO fill with no early pop.** If the FSM never pops, a full FIFO holds `FIFO_DEPTH` bytes. A simultaneous push with a pop is allowed whenever `!full`.
- **Burst from idle.** With pushes every cycle starting from empty and idle, 17 bytes are accepted before `ready_in` drops at the default depth. The first byte is popped on edge N+1.
- **Recovery from full.** `ready_in` returns high on the cycle after a pop from a full FIFO.

## Test plan
- **Single byte.** Push 0xA5 once at the defaults.
  - `RsTx` sequence, 33 cycles per bit: 0, then 1,0,1,0,0,1,0,1, then 1.
  - Start bit begins the cycle after the pop.
  - A looped-back `uart_rx` outputs 0xA5.
  - `busy` falls 330 cycles after the pop.
- **Burst with backpressure.** Hold `valid_in` and present bytes 0..39, advancing only on handshake.
  - `ready_in` drops after 17 accepts.
  - `fifo_count` peaks at 16.
  - `uart_rx` receives 0..39 in order, with no loss or duplicates.
  - Start bits are exactly 330 cycles apart.
- **Reset mid-frame.** Assert `rst` for 1 cycle during data bit 3 with 5 bytes queued.
  - `RsTx`=1 the next cycle.
  - `fifo_count`=0 and `busy`=0.
  - A subsequent push of 0x3C transmits correctly.
- **Two stop bits.** With `STOP_BITS=2`, push 0x00 then 0xFF.
  - Stop phase is 66 cycles.
  - Frame period is 363 cycles.
  - Both bytes are decoded correctly.
- **Simultaneous push/pop and pointer wrap.** Push 100 bytes at random intervals so that pushes coincide with STOP→START pops.
  - `fifo_count` stays consistent.
  - Pointers wrap past 15 without corruption.
  - All 100 bytes are received in order.
- **Idle line.** After reset, with `valid_in`=0 for 10000 cycles:
  - `RsTx` stays 1;
  - `busy` stays 0;
  - `ready_in` stays 1.
